// File: rtl/req_encoder.sv
// rtl/req_encoder.sv - request vector to per-bit index beat encoder
module req_encoder #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b0,
    localparam int W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         out_none,
    output logic         busy
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t         state, state_d;
    logic [N-1:0]   pend, pend_d;
    logic           none_q, none_d;
    logic [N-1:0]   sel;
    logic [W-1:0]   idx;
    logic           single;

    // Pick the next bit to emit from the held vector; later loop iterations win,
    // so the loop direction sets the priority order.
    always_comb begin
        idx = '0;
        sel = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    idx    = W'(i);
                    sel    = '0;
                    sel[i] = 1'b1;
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pend[i]) begin
                    idx    = W'(i);
                    sel    = '0;
                    sel[i] = 1'b1;
                end
            end
        end
    end

    // At most one bit left means the current beat closes this vector.
    assign single = ((pend & (pend - N'(1))) == '0);

    // Outputs depend only on registered state, never on in_* or out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == EMIT);
    assign busy      = (state == EMIT);
    assign out_idx   = ((state == EMIT) && !none_q) ? idx : '0;
    assign out_none  = (state == EMIT) && none_q;
    assign out_last  = (state == EMIT) && single;

    // Next-state logic: capture a vector in IDLE, retire one bit per accepted beat in EMIT.
    always_comb begin
        state_d = state;
        pend_d  = pend;
        none_d  = none_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    pend_d  = in_vec;
                    none_d  = (in_vec == '0);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pend_d = pend & ~sel;
                    if (single) begin
                        none_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
                none_d  = 1'b0;
            end
        endcase
    end

    // State, held vector and all-zero flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pend   <= '0;
            none_q <= 1'b0;
        end else begin
            state  <= state_d;
            pend   <= pend_d;
            none_q <= none_d;
        end
    end

endmodule
